// File: rtl/rtc_pkg.sv
// Shared BCD layout, digit limits and alarm state for the time-of-day counter.
// Time word is {h_t,h_u,m_t,m_u,s_t,s_u}, 4 bits per digit.
package rtc_pkg;

  localparam int S_U_OFF = 0;
  localparam int S_T_OFF = 4;
  localparam int M_U_OFF = 8;
  localparam int M_T_OFF = 12;
  localparam int H_U_OFF = 16;
  localparam int H_T_OFF = 20;
  localparam int DIG_W   = 4;

  localparam logic [3:0] D_MAX   = 4'd9;
  localparam logic [3:0] S_T_MAX = 4'd5;
  localparam logic [3:0] M_T_MAX = 4'd5;
  localparam logic [3:0] H_T_MAX = 4'd2;
  localparam int         H_MAX   = 23;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_RING = 1'b1
  } alarm_st_t;

  function automatic logic time_ok(input logic [23:0] t);
    logic ok;
    int   hrs;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[i*DIG_W +: DIG_W] > D_MAX) ok = 1'b0;
    if (t[S_T_OFF +: DIG_W] > S_T_MAX) ok = 1'b0;
    if (t[M_T_OFF +: DIG_W] > M_T_MAX) ok = 1'b0;
    if (t[H_T_OFF +: DIG_W] > H_T_MAX) ok = 1'b0;
    hrs = int'(t[H_T_OFF +: DIG_W]) * 10 + int'(t[H_U_OFF +: DIG_W]);
    if (hrs > H_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rtc_hms_digit.sv
// One BCD digit: load > clear > increment, wraps to 0 after MAX.
// carry flags the increment that wraps this digit.
module bcd_digit_cnt
  import rtc_pkg::*;
#(
  parameter logic [3:0] MAX = D_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (load) r_q <= load_val;
    else if (clr)  r_q <= '0;
    else if (inc)  r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
  end

  assign q     = r_q;
  assign carry = inc & (r_q == MAX);

endmodule

// File: rtl/rtc_hms.sv
// BCD hh:mm:ss time-of-day counter driven by the 1 Hz divider output,
// with validated load handshake and a self-timing alarm.
module rtc_hms
  import rtc_pkg::*;
#(
  parameter int RING_SECS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        run,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [23:0] set_time,
  output logic        set_err,
  input  logic        alarm_en,
  input  logic [15:0] alarm_time,
  input  logic        alarm_ack,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        alarm_ring
);

  logic        r_tick_q;
  logic        r_ready;
  logic        r_err;
  logic        r_sp;
  logic        r_dw;
  alarm_st_t   r_st;
  logic [7:0]  r_cnt;

  logic        w_rise;
  logic        w_load;
  logic        w_ok;
  logic        w_adv;
  logic        w_h23;
  logic        w_hwrap;
  logic        w_al_ok;
  logic        w_match;
  logic        w_exit;
  logic [5:0]  w_inc;
  logic [5:0]  w_c;
  logic [23:0] w_t;
  logic [15:0] w_nhm;

  assign w_rise = tick_in & ~r_tick_q;
  assign w_load = set_valid & r_ready;
  assign w_ok   = time_ok(set_time);
  assign w_adv  = w_rise & run & ~w_load;

  // 23 -> 00 overrides the natural 9 -> 0 hour-units wrap
  assign w_h23   = (w_t[H_T_OFF +: 4] == 4'd2) &&
                   (w_t[H_U_OFF +: 4] == 4'd3);
  assign w_hwrap = w_c[3] & w_h23;

  assign w_inc[0] = w_adv;
  assign w_inc[1] = w_c[0];
  assign w_inc[2] = w_c[1];
  assign w_inc[3] = w_c[2];
  assign w_inc[4] = w_c[3];
  assign w_inc[5] = w_c[4] | w_hwrap;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    localparam logic [3:0] MX =
      (i == 1) ? S_T_MAX :
      (i == 3) ? M_T_MAX :
      (i == 5) ? H_T_MAX : D_MAX;
    bcd_digit_cnt #(.MAX(MX)) u_dig (
      .clk      (clk),
      .rst      (rst),
      .inc      (w_inc[i]),
      .load     (w_load & w_ok),
      .load_val (set_time[i*4 +: 4]),
      .clr      ((i == 4) ? w_hwrap : 1'b0),
      .q        (w_t[i*4 +: 4]),
      .carry    (w_c[i])
    );
  end

  // hh:mm the counter shows after the next minute rollover
  always_comb begin
    w_nhm = w_t[23:8];
    if (w_t[11:8] == 4'd9) begin
      w_nhm[3:0] = 4'd0;
      if (w_t[15:12] == 4'd5) begin
        w_nhm[7:4] = 4'd0;
        if (w_h23)
          w_nhm[15:8] = 8'h00;
        else if (w_t[19:16] == 4'd9) begin
          w_nhm[11:8]  = 4'd0;
          w_nhm[15:12] = w_t[23:20] + 4'd1;
        end else
          w_nhm[11:8] = w_t[19:16] + 4'd1;
      end else
        w_nhm[7:4] = w_t[15:12] + 4'd1;
    end else
      w_nhm[3:0] = w_t[11:8] + 4'd1;
  end

  assign w_al_ok = time_ok({alarm_time, 8'h00});
  assign w_match = w_adv & alarm_en & w_al_ok &
                   (w_t[7:0] == 8'h59) &
                   (w_nhm == alarm_time);
  assign w_exit  = alarm_ack | ~alarm_en |
                   (r_cnt == 8'(RING_SECS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_q <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_sp     <= 1'b0;
      r_dw     <= 1'b0;
    end else begin
      r_tick_q <= tick_in;
      r_ready  <= 1'b1;
      r_err    <= w_load & ~w_ok;
      r_sp     <= w_adv;
      r_dw     <= w_c[5];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= A_IDLE;
      r_cnt <= 8'd0;
    end else begin
      case (r_st)
        A_IDLE: begin
          if (w_match) begin
            r_st  <= A_RING;
            r_cnt <= 8'd0;
          end
        end
        A_RING: begin
          if (w_exit) begin
            r_st  <= A_IDLE;
            r_cnt <= 8'd0;
          end else if (w_adv)
            r_cnt <= r_cnt + 8'd1;
        end
        default: begin
          r_st  <= A_IDLE;
          r_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign set_ready  = r_ready;
  assign set_err    = r_err;
  assign sec_pulse  = r_sp;
  assign day_wrap   = r_dw;
  assign time_bcd   = w_t;
  assign alarm_ring = (r_st == A_RING);

endmodule
